// File: rtl/vga_640x480_sync.sv
// VGA 640x480@60 timing generator: pixel-rate divider, hc/vc counters,
// active-low hsync/vsync, vidon window, pix_en strobe, frame_start pulse.
//
// Ports:
//   clk          board clock, rising edge
//   clr          asynchronous active-high reset
//   hsync/vsync  active-low sync, decoded from hc/vc
//   hc, vc       10-bit pixel / line counters
//   vidon        high inside the visible window
//   pix_en       one-clk strobe marking the clk in which new hc/vc appear
//   frame_start  one-clk pulse in the first clk showing hc=0, vc=0
module vga_640x480_sync #(
    parameter int unsigned HPIXELS = 800,
    parameter int unsigned VLINES  = 521,
    parameter int unsigned HSW     = 128,
    parameter int unsigned VSW     = 2,
    parameter int unsigned HBP     = 144,
    parameter int unsigned HFP     = 784,
    parameter int unsigned VBP     = 31,
    parameter int unsigned VFP     = 511,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       clr,
    output logic       hsync,
    output logic       vsync,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       vidon,
    output logic       pix_en,
    output logic       frame_start
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0]    H_LAST   = 10'(HPIXELS - 1);
    localparam logic [9:0]    V_LAST   = 10'(VLINES - 1);
    localparam logic [9:0]    H_SW     = 10'(HSW);
    localparam logic [9:0]    V_SW     = 10'(VSW);
    localparam logic [9:0]    H_BP     = 10'(HBP);
    localparam logic [9:0]    H_FP     = 10'(HFP);
    localparam logic [9:0]    V_BP     = 10'(VBP);
    localparam logic [9:0]    V_FP     = 10'(VFP);

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    hc_q, hc_d;
    logic [9:0]    vc_q, vc_d;
    logic          pix_en_q, pix_en_d;
    logic          frame_start_q, frame_start_d;
    logic          tick;
    logic          h_wrap;
    logic          v_wrap;

    // The counters step on the same edge that raises pix_en, so pix_en
    // flags the clk in which a fresh hc/vc pair is first presented.
    always_comb begin
        tick   = (div_q == DIV_LAST);
        h_wrap = (hc_q == H_LAST);
        v_wrap = (vc_q == V_LAST);
        div_d  = tick ? '0 : div_q + 1'b1;
        hc_d   = hc_q;
        vc_d   = vc_q;
        if (tick) begin
            if (h_wrap) begin
                hc_d = '0;
                vc_d = v_wrap ? '0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
        pix_en_d      = tick;
        frame_start_d = tick && h_wrap && v_wrap;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            div_q         <= '0;
            hc_q          <= '0;
            vc_q          <= '0;
            pix_en_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            pix_en_q      <= pix_en_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hc          = hc_q;
    assign vc          = vc_q;
    assign pix_en      = pix_en_q;
    assign frame_start = frame_start_q;
    assign hsync       = (hc_q >= H_SW);
    assign vsync       = (vc_q >= V_SW);
    assign vidon       = (hc_q >= H_BP) && (hc_q < H_FP)
                      && (vc_q >= V_BP) && (vc_q < V_FP);

endmodule

// File: tb/tb_vga_640x480_sync.sv
// Bench for vga_640x480_sync: full-size instance for reset/line/window,
// scaled instance for frame, mid-frame reset and random reset pulses.
module tb_vga_640x480_sync;

    logic       clk = 1'b0;
    logic       clr_a = 1'b1;
    logic       clr_b = 1'b1;
    logic       hsync_a, vsync_a, vidon_a, pix_en_a, fs_a;
    logic [9:0] hc_a, vc_a;
    logic       hsync_b, vsync_b, vidon_b, pix_en_b, fs_b;
    logic [9:0] hc_b, vc_b;
    int         tests = 0;
    int         fails = 0;
    int         ta = 0;
    int         tb = 0;

    always #5 clk = ~clk;

    vga_640x480_sync u_a (
        .clk(clk), .clr(clr_a), .hsync(hsync_a), .vsync(vsync_a),
        .hc(hc_a), .vc(vc_a), .vidon(vidon_a), .pix_en(pix_en_a),
        .frame_start(fs_a)
    );

    vga_640x480_sync #(
        .HPIXELS(40), .VLINES(25), .HSW(6), .VSW(2), .HBP(9),
        .HFP(33), .VBP(4), .VFP(21), .CLK_DIV(2)
    ) u_b (
        .clk(clk), .clr(clr_b), .hsync(hsync_b), .vsync(vsync_b),
        .hc(hc_b), .vc(vc_b), .vidon(vidon_b), .pix_en(pix_en_b),
        .frame_start(fs_b)
    );

    // clk edges seen since reset release
    always @(posedge clk or posedge clr_a)
        if (clr_a) ta <= 0; else ta <= ta + 1;
    always @(posedge clk or posedge clr_b)
        if (clr_b) tb <= 0; else tb <= tb + 1;

    wire [24:0] obs_a = {hsync_a, vsync_a, vidon_a, pix_en_a, fs_a, hc_a, vc_a};
    wire [24:0] obs_b = {hsync_b, vsync_b, vidon_b, pix_en_b, fs_b, hc_b, vc_b};

    // Expected outputs after t edges: pixel index p = t / cd,
    // hc/vc are its position in the raster.
    function automatic logic [24:0] model(input int t, hp, vl, cd,
                                          hsw, vsw, hbp, hfp, vbp, vfp);
        int p, h, v;
        logic pe, fs, hs, vs, vo;
        p  = t / cd;
        h  = p % hp;
        v  = (p / hp) % vl;
        pe = (t > 0) && (t % cd == 0);
        fs = pe && (p % (hp * vl) == 0);
        hs = (h >= hsw);
        vs = (v >= vsw);
        vo = (h >= hbp) && (h < hfp) && (v >= vbp) && (v < vfp);
        return {hs, vs, vo, pe, fs, 10'(h), 10'(v)};
    endfunction

    function automatic logic [24:0] mdl_a(input int t);
        return model(t, 800, 521, 2, 128, 2, 144, 784, 31, 511);
    endfunction

    function automatic logic [24:0] mdl_b(input int t);
        return model(t, 40, 25, 2, 6, 2, 9, 33, 4, 21);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr_a = 1'b1;
        clr_b = 1'b1;
        repeat (3) step();
        tests++;
        if (obs_a !== 25'd0) begin
            fails++;
            $display("FAIL reset_a: got %h want 0", obs_a);
        end
        tests++;
        if (obs_b !== 25'd0) begin
            fails++;
            $display("FAIL reset_b: got %h want 0", obs_b);
        end
        clr_a = 1'b0;
        clr_b = 1'b0;
        step();
        tests++;
        if ({pix_en_a, hc_a, vc_a} !== {1'b0, 10'd0, 10'd0}) begin
            fails++;
            $display("FAIL edge1_a: pix_en=%b hc=%0d vc=%0d want 0 0 0",
                     pix_en_a, hc_a, vc_a);
        end
        tests++;
        if ({pix_en_b, hc_b} !== {1'b0, 10'd0}) begin
            fails++;
            $display("FAIL edge1_b: pix_en=%b hc=%0d want 0 0", pix_en_b, hc_b);
        end
        step();
        tests++;
        if ({pix_en_a, hc_a, vc_a} !== {1'b1, 10'd1, 10'd0}) begin
            fails++;
            $display("FAIL edge2_a: pix_en=%b hc=%0d vc=%0d want 1 1 0",
                     pix_en_a, hc_a, vc_a);
        end
        tests++;
        if ({pix_en_b, hc_b, fs_b} !== {1'b1, 10'd1, 1'b0}) begin
            fails++;
            $display("FAIL edge2_b: pix_en=%b hc=%0d fs=%b want 1 1 0",
                     pix_en_b, hc_b, fs_b);
        end
    endtask

    task automatic test_line();
        int err = 0, low = 0, high = 0;
        logic [9:0] ph, pv;
        ph = hc_a;
        pv = vc_a;
        while (ta < 3202) begin
            step();
            if (obs_a !== mdl_a(ta)) err++;
            if (vc_a == 10'd1) begin
                if (!hsync_a) low++; else high++;
            end
            if (ph == 10'd799 && hc_a == 10'd0) begin
                tests++;
                if (vc_a !== pv + 10'd1) begin
                    fails++;
                    $display("FAIL line_wrap_vc: got %0d want %0d", vc_a, pv + 10'd1);
                end
            end
            ph = hc_a;
            pv = vc_a;
        end
        tests++;
        if (err !== 0) begin
            fails++;
            $display("FAIL line_model: %0d bad clks, want 0", err);
        end
        tests++;
        if (low !== 256 || high !== 1344) begin
            fails++;
            $display("FAIL line_hsync: low=%0d high=%0d want 256 1344", low, high);
        end
    endtask

    task automatic test_visible();
        int err = 0, v30 = 0, v31 = 0, rise = -1, fall = -1;
        logic pvid;
        pvid = vidon_a;
        while (ta < 51204) begin
            step();
            if (obs_a !== mdl_a(ta)) err++;
            if (vc_a == 10'd30 && vidon_a) v30++;
            if (vc_a == 10'd31) begin
                if (vidon_a) v31++;
                if (vidon_a && !pvid) rise = int'(hc_a);
                if (!vidon_a && pvid) fall = int'(hc_a);
            end
            pvid = vidon_a;
        end
        tests++;
        if (err !== 0) begin
            fails++;
            $display("FAIL vis_model: %0d bad clks, want 0", err);
        end
        tests++;
        if (v30 !== 0) begin
            fails++;
            $display("FAIL vis_line30: vidon clks=%0d want 0", v30);
        end
        tests++;
        if (rise !== 144 || fall !== 784 || v31 !== 1280) begin
            fails++;
            $display("FAIL vis_line31: rise=%0d fall=%0d clks=%0d want 144 784 1280",
                     rise, fall, v31);
        end
        clr_a = 1'b1;
    endtask

    task automatic test_frame();
        int err = 0, nfs = 0, last = -1, n = 0, werr = 0, cerr = 0;
        int vfp_vid = 0, wraps = 0, maxh = 0, maxv = 0;
        logic [31:0] vmask = '0;
        logic [9:0] ph, pv;
        logic pfs;
        clr_b = 1'b1;
        step();
        clr_b = 1'b0;
        ph = 10'd0;
        pv = 10'd0;
        pfs = 1'b0;
        while (tb < 4004) begin
            step();
            n++;
            if (obs_b !== mdl_b(tb)) err++;
            if (fs_b) begin
                nfs++;
                if (pfs) werr++;
                if (last >= 0) begin
                    tests++;
                    if (n - last !== 2000) begin
                        fails++;
                        $display("FAIL frame_period: got %0d want 2000", n - last);
                    end
                end
                last = n;
            end
            if (!vsync_b) vmask[vc_b[4:0]] = 1'b1;
            if (vc_b == 10'd21 && vidon_b) vfp_vid++;
            if (int'(hc_b) > maxh) maxh = int'(hc_b);
            if (int'(vc_b) > maxv) maxv = int'(vc_b);
            if (pix_en_b && hc_b !== 10'((int'(ph) + 1) % 40)) cerr++;
            if (vc_b !== pv && !(pix_en_b && hc_b == 10'd0)) cerr++;
            if (pv == 10'd24 && vc_b == 10'd0) wraps++;
            ph = hc_b;
            pv = vc_b;
            pfs = fs_b;
        end
        tests++;
        if (err !== 0) begin
            fails++;
            $display("FAIL frame_model: %0d bad clks, want 0", err);
        end
        tests++;
        if (nfs !== 2 || werr !== 0) begin
            fails++;
            $display("FAIL frame_start: pulses=%0d wide=%0d want 2 0", nfs, werr);
        end
        tests++;
        if (vmask !== 32'h3) begin
            fails++;
            $display("FAIL frame_vsync: lines=%h want 3", vmask);
        end
        tests++;
        if (vfp_vid !== 0) begin
            fails++;
            $display("FAIL frame_vfp_vidon: clks=%0d want 0", vfp_vid);
        end
        tests++;
        if (cerr !== 0 || wraps !== 2) begin
            fails++;
            $display("FAIL frame_counter: errs=%0d wraps=%0d want 0 2", cerr, wraps);
        end
        tests++;
        if (maxh !== 39 || maxv !== 24) begin
            fails++;
            $display("FAIL frame_max: hc=%0d vc=%0d want 39 24", maxh, maxv);
        end
    endtask

    task automatic test_mid_reset();
        int k = 0;
        while (!(pix_en_b && hc_b == 10'd20 && vc_b == 10'd10) && k < 3000) begin
            step();
            k++;
        end
        tests++;
        if (k >= 3000) begin
            fails++;
            $display("FAIL mid_reach: timeout got hc=%0d vc=%0d want 20 10", hc_b, vc_b);
        end
        #3;
        clr_b = 1'b1;
        #1;
        tests++;
        if (obs_b !== 25'd0) begin
            fails++;
            $display("FAIL mid_async: got %h want 0 before edge", obs_b);
        end
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        clr_b = 1'b0;
        step();
        tests++;
        if ({pix_en_b, hc_b, vc_b} !== {1'b0, 10'd0, 10'd0}) begin
            fails++;
            $display("FAIL mid_edge1: pix_en=%b hc=%0d vc=%0d want 0 0 0",
                     pix_en_b, hc_b, vc_b);
        end
        step();
        tests++;
        if ({pix_en_b, hc_b, vc_b} !== {1'b1, 10'd1, 10'd0}) begin
            fails++;
            $display("FAIL mid_edge2: pix_en=%b hc=%0d vc=%0d want 1 1 0",
                     pix_en_b, hc_b, vc_b);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int err = 0;
            int n;
            n = int'($urandom_range(100, 2000));
            for (int i = 0; i < n; i++) begin
                step();
                if (obs_b !== mdl_b(tb)) err++;
            end
            tests++;
            if (err !== 0) begin
                fails++;
                $display("FAIL rand_run%0d: %0d bad clks, want 0", it, err);
            end
            #($urandom_range(1, 7));
            clr_b = 1'b1;
            #1;
            tests++;
            if (obs_b !== 25'd0) begin
                fails++;
                $display("FAIL rand_clr%0d: got %h want 0", it, obs_b);
            end
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            clr_b = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_visible();
        test_frame();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
